// File: rtl/freq_detect_pkg.sv
// Shared definitions for the frequency-detect result path: accumulator states,
// flag bit positions and the warning-run saturation helper.
package freq_detect_pkg;

  typedef enum logic [1:0] {
    ACC_IDLE = 2'b00,
    ACC_RUN  = 2'b01,
    ACC_EMIT = 2'b10
  } acc_state_t;

  localparam int FLAG_WARN  = 0;
  localparam int FLAG_STUCK = 1;
  localparam int FLAG_W     = 2;

  localparam logic [3:0] WARN_RUN_MAX = 4'd15;

  function automatic logic [3:0] warn_run_inc(input logic [3:0] run);
    return (run == WARN_RUN_MAX) ? run : run + 4'd1;
  endfunction

endpackage

// File: rtl/freq_result_monitor_if.sv
// Read port of the result history FIFO: show-ahead head entry, occupancy and
// the consumer's ready. master = monitor side, slave = consumer side.
interface freq_result_monitor_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
);
  import freq_detect_pkg::*;

  logic                    Rd_valid_o;
  logic [WIDTH-1:0]        Rd_data_o;
  logic [FLAG_W-1:0]       Rd_flags_o;
  logic [$clog2(DEPTH):0]  Count_o;
  logic                    Rd_ready_i;

  modport master (
    output Rd_valid_o,
    output Rd_data_o,
    output Rd_flags_o,
    output Count_o,
    input  Rd_ready_i
  );

  modport slave (
    input  Rd_valid_o,
    input  Rd_data_o,
    input  Rd_flags_o,
    input  Count_o,
    output Rd_ready_i
  );

endinterface

// File: rtl/freq_result_fifo.sv
// Show-ahead FIFO: registered storage with a combinational head mux. A write
// into a full FIFO is accepted only when a read frees a slot in the same cycle.
module freq_result_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 4
) (
  input  logic                   Clk_ref_i_muxed,
  input  logic                   rstn_muxed,
  input  logic                   clr,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_ready,
  output logic                   rd_valid,
  output logic [WIDTH-1:0]       rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   wr_drop
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             empty, full, do_rd, do_wr;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CNT_W'(DEPTH));
  assign do_rd   = rd_ready & ~empty & ~clr;
  assign do_wr   = wr_en & ~clr & (~full | do_rd);
  assign wr_drop = wr_en & ~clr & ~do_wr;

  always_ff @(posedge Clk_ref_i_muxed or negedge rstn_muxed) begin
    if (!rstn_muxed) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (clr) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_wr) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (do_rd) rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({do_wr, do_rd})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage carries no reset: contents are meaningless while the slot is unoccupied.
  always_ff @(posedge Clk_ref_i_muxed) begin
    if (do_wr) mem[wr_ptr_reg] <= wr_data;
  end

  assign rd_valid = ~empty;
  assign rd_data  = mem[rd_ptr_reg];
  assign count    = count_reg;

endmodule

// File: rtl/freq_result_monitor.sv
// Captures detector results into a history FIFO, tracks overflow and a sticky alarm,
// and block-averages captures when built with FREQ_RESULT_MON_AVG_EN.
module freq_result_monitor
  import freq_detect_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 4,
  parameter int AVG_LOG2  = 2,
  parameter int ALARM_CNT = 3
) (
  input  logic                  Clk_ref_i_muxed,
  input  logic                  rstn_muxed,
  input  logic                  Finish_i,
  input  logic [WIDTH-1:0]      Result_i,
  input  logic                  Warning_i,
  input  logic                  Stuck_i,
  input  logic                  Clear_i,
  freq_result_monitor_if.master rd_if,
  output logic                  Overflow_o,
  output logic [WIDTH-1:0]      Avg_o,
  output logic                  Avg_valid_o,
  output logic                  Alarm_o
);

  localparam int PW = WIDTH + FLAG_W;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || ALARM_CNT < 1 || ALARM_CNT > 15
      || AVG_LOG2 < 0) begin : g_bad_params
    $error("freq_result_monitor: illegal parameter combination");
  end

  logic              capture;
  logic [FLAG_W-1:0] cap_flags;
  logic [PW-1:0]     head;
  logic              fifo_drop;
  logic [3:0]        warn_run_reg, warn_run_inc_w;
  logic              overflow_reg, alarm_reg;

  // Clear wins over a coincident strobe; that capture touches nothing.
  assign capture = Finish_i & ~Clear_i;

  always_comb begin
    cap_flags             = '0;
    cap_flags[FLAG_WARN]  = Warning_i;
    cap_flags[FLAG_STUCK] = Stuck_i;
  end

  freq_result_fifo #(
    .WIDTH (PW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .Clk_ref_i_muxed (Clk_ref_i_muxed),
    .rstn_muxed      (rstn_muxed),
    .clr             (Clear_i),
    .wr_en           (capture),
    .wr_data         ({cap_flags, Result_i}),
    .rd_ready        (rd_if.Rd_ready_i),
    .rd_valid        (rd_if.Rd_valid_o),
    .rd_data         (head),
    .count           (rd_if.Count_o),
    .wr_drop         (fifo_drop)
  );

  assign rd_if.Rd_data_o  = head[WIDTH-1:0];
  assign rd_if.Rd_flags_o = head[PW-1:WIDTH];

  assign warn_run_inc_w = warn_run_inc(warn_run_reg);

  always_ff @(posedge Clk_ref_i_muxed or negedge rstn_muxed) begin
    if (!rstn_muxed) begin
      warn_run_reg <= '0;
      overflow_reg <= 1'b0;
      alarm_reg    <= 1'b0;
    end else if (Clear_i) begin
      warn_run_reg <= '0;
      overflow_reg <= 1'b0;
      alarm_reg    <= 1'b0;
    end else begin
      if (fifo_drop) overflow_reg <= 1'b1;
      if (capture) begin
        if (Warning_i) begin
          warn_run_reg <= warn_run_inc_w;
          if (warn_run_inc_w >= 4'(ALARM_CNT)) alarm_reg <= 1'b1;
        end else begin
          warn_run_reg <= '0;
        end
        if (Stuck_i) alarm_reg <= 1'b1;
      end
    end
  end

  assign Overflow_o = overflow_reg;
  assign Alarm_o    = alarm_reg;

`ifdef FREQ_RESULT_MON_AVG_EN
  localparam int                SUM_W   = WIDTH + AVG_LOG2;
  localparam logic [AVG_LOG2:0] WIN_CNT = (AVG_LOG2 + 1)'(1 << AVG_LOG2);

  acc_state_t        acc_state_reg, acc_state_next;
  logic [SUM_W-1:0]  sum_reg, sum_next, sum_base;
  logic [AVG_LOG2:0] win_cnt_reg, win_cnt_next, cnt_base;
  logic [WIDTH-1:0]  avg_reg, avg_next;

  always_ff @(posedge Clk_ref_i_muxed or negedge rstn_muxed) begin
    if (!rstn_muxed) begin
      acc_state_reg <= ACC_IDLE;
      sum_reg       <= '0;
      win_cnt_reg   <= '0;
      avg_reg       <= '0;
    end else begin
      acc_state_reg <= acc_state_next;
      sum_reg       <= sum_next;
      win_cnt_reg   <= win_cnt_next;
      avg_reg       <= avg_next;
    end
  end

  // Outside ACC_RUN a capture opens a fresh window, which is what lets a capture
  // landing in the ACC_EMIT cycle start the next block without being lost.
  always_comb begin
    acc_state_next = acc_state_reg;
    sum_next       = sum_reg;
    win_cnt_next   = win_cnt_reg;
    avg_next       = avg_reg;
    sum_base       = (acc_state_reg == ACC_RUN) ? sum_reg : '0;
    cnt_base       = (acc_state_reg == ACC_RUN) ? win_cnt_reg : '0;
    if (Clear_i) begin
      acc_state_next = ACC_IDLE;
      sum_next       = '0;
      win_cnt_next   = '0;
    end else if (capture) begin
      sum_next     = sum_base + SUM_W'(Result_i);
      win_cnt_next = cnt_base + (AVG_LOG2 + 1)'(1);
      if (win_cnt_next == WIN_CNT) begin
        acc_state_next = ACC_EMIT;
        avg_next       = WIDTH'(sum_next >> AVG_LOG2);
      end else begin
        acc_state_next = ACC_RUN;
      end
    end else if (acc_state_reg == ACC_EMIT) begin
      acc_state_next = ACC_IDLE;
    end
  end

  assign Avg_o       = avg_reg;
  assign Avg_valid_o = (acc_state_reg == ACC_EMIT);
`else
  assign Avg_o       = '0;
  assign Avg_valid_o = 1'b0;
`endif

endmodule
